// File: rtl/branch_seq.sv
// rtl/branch_seq.sv - three-phase compare/branch sequencer (FETCH, EXEC, UPDATE)
module branch_seq #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    input  logic [PC_W-1:0]   target,
    output logic [2:0]        cmp_op,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic [DATA_W-1:0] cmp_rd,
    output logic [PC_W-1:0]   pc,
    output logic              flag,
    output logic              taken,
    output logic              busy
);
    typedef enum logic [1:0] {FETCH, EXEC, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flag_q, flag_d;
    logic              result_q, result_d;
    logic              is_branch;
    logic [PC_W-1:0]   pc_inc;

    // Opcodes 110/111 are branches that test the stored flag, not the operands
    assign is_branch = op_q[2] & op_q[1];
    assign pc_inc    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc        = pc_q;
    assign flag      = flag_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        target_d    = target_q;
        pc_d        = pc_q;
        flag_d      = flag_q;
        result_d    = result_q;
        instr_ready = 1'b0;
        busy        = 1'b0;
        taken       = 1'b0;
        cmp_op      = 3'd0;
        cmp_a       = '0;
        cmp_b       = '0;
        case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d     = op;
                    r1_d     = r1;
                    r2_d     = r2;
                    target_d = target;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                busy   = 1'b1;
                cmp_op = op_q;
                if (is_branch) begin
                    cmp_a = {{(DATA_W-1){1'b0}}, flag_q};
                end else begin
                    cmp_a = r1_q;
                    cmp_b = r2_q;
                end
                result_d = |cmp_rd;
                state_d  = UPDATE;
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = FETCH;
                if (!is_branch) begin
                    flag_d = result_q;
                    pc_d   = pc_inc;
                end else if (result_q) begin
                    pc_d  = target_q;
                    taken = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            op_q     <= 3'd0;
            r1_q     <= '0;
            r2_q     <= '0;
            target_q <= '0;
            pc_q     <= '0;
            flag_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            target_q <= target_d;
            pc_q     <= pc_d;
            flag_q   <= flag_d;
            result_q <= result_d;
        end
    end
endmodule
